// File: rtl/branch_resolver_if.sv
// Request/response bundle between the execute pipeline and branch_resolver.
// The master drives requests and flush; the slave returns the resolved branch.
interface branch_resolver_if #(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            misaligned;
    logic            error;

    modport master (
        output flush, in_valid, funct3, a, b, pc, imm, pred_taken, out_ready,
        input  in_ready, out_valid, taken, target, mispredict, misaligned, error
    );

    modport slave (
        input  flush, in_valid, funct3, a, b, pc, imm, pred_taken, out_ready,
        output in_ready, out_valid, taken, target, mispredict, misaligned, error
    );
endinterface

// File: rtl/branch_resolver.sv
// Multi-cycle branch resolver: compares rs1/rs2 one CHUNK-bit slice per cycle,
// MSB slice first, then registers taken/target/mispredict for the consumer.
module branch_resolver #(
    parameter int XLEN       = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    branch_resolver_if.slave   bus
);
    localparam int N     = XLEN / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       f3_q, f3_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, pc_q, pc_d, imm_q, imm_d;
    logic             pred_q, pred_d;
    logic             diff_q, diff_d, lt_q, lt_d;
    logic             valid_q, valid_d;
    logic             taken_q, taken_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             mispredict_q, mispredict_d;
    logic             misaligned_q, misaligned_d;
    logic             error_q, error_d;

    logic             in_ready_s, accept_s, illegal_s, finish_s;
    logic [XLEN-1:0]  sign_mask_s, a_cmp_s, b_cmp_s, tgt_s;
    logic [CHUNK-1:0] sa_s, sb_s;
    logic             sl_diff_s, diff_now_s, lt_now_s, cond_s;

    assign in_ready_s = !rst && !bus.flush &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    assign accept_s   = in_ready_s && bus.in_valid;

    // Slice compare and condition decode from the latched operation.
    always_comb begin
        illegal_s   = (f3_q[2:1] == 2'b01);
        // Flipping the sign bit turns a signed compare into an unsigned one.
        sign_mask_s = (f3_q[2:1] == 2'b10) ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b0}};
        a_cmp_s     = a_q ^ sign_mask_s;
        b_cmp_s     = b_q ^ sign_mask_s;
        sa_s        = a_cmp_s[idx_q*CHUNK +: CHUNK];
        sb_s        = b_cmp_s[idx_q*CHUNK +: CHUNK];
        sl_diff_s   = (sa_s != sb_s);
        diff_now_s  = diff_q || sl_diff_s;
        lt_now_s    = diff_q ? lt_q : (sa_s < sb_s);
        finish_s    = illegal_s || (sl_diff_s && (EARLY_EXIT != 0)) || (idx_q == {IDX_W{1'b0}});
        case (f3_q)
            3'b000:  cond_s = !diff_now_s;
            3'b001:  cond_s = diff_now_s;
            3'b100:  cond_s = lt_now_s;
            3'b101:  cond_s = !lt_now_s;
            3'b110:  cond_s = lt_now_s;
            3'b111:  cond_s = !lt_now_s;
            default: cond_s = 1'b0;
        endcase
        tgt_s = cond_s ? (pc_q + imm_q) : (pc_q + XLEN'(32'd4));
    end

    // Next-state logic: flush beats accept, accept beats the running compare.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        f3_d         = f3_q;
        a_d          = a_q;
        b_d          = b_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        pred_d       = pred_q;
        diff_d       = diff_q;
        lt_d         = lt_q;
        valid_d      = valid_q;
        taken_d      = taken_q;
        target_d     = target_q;
        mispredict_d = mispredict_q;
        misaligned_d = misaligned_q;
        error_d      = error_q;
        if (bus.flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (accept_s) begin
            state_d = BUSY;
            idx_d   = IDX_TOP;
            f3_d    = bus.funct3;
            a_d     = bus.a;
            b_d     = bus.b;
            pc_d    = bus.pc;
            imm_d   = bus.imm;
            pred_d  = bus.pred_taken;
            diff_d  = 1'b0;
            lt_d    = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                BUSY: begin
                    diff_d = diff_now_s;
                    lt_d   = lt_now_s;
                    if (finish_s) begin
                        state_d      = DONE;
                        valid_d      = 1'b1;
                        taken_d      = cond_s;
                        target_d     = tgt_s;
                        mispredict_d = !illegal_s && (cond_s ^ pred_q);
                        misaligned_d = cond_s && (tgt_s[1:0] != 2'b00);
                        error_d      = illegal_s;
                    end else begin
                        idx_d = idx_q - IDX_ONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= {IDX_W{1'b0}};
            f3_q         <= 3'b000;
            a_q          <= {XLEN{1'b0}};
            b_q          <= {XLEN{1'b0}};
            pc_q         <= {XLEN{1'b0}};
            imm_q        <= {XLEN{1'b0}};
            pred_q       <= 1'b0;
            diff_q       <= 1'b0;
            lt_q         <= 1'b0;
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= {XLEN{1'b0}};
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            f3_q         <= f3_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            pred_q       <= pred_d;
            diff_q       <= diff_d;
            lt_q         <= lt_d;
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            mispredict_q <= mispredict_d;
            misaligned_q <= misaligned_d;
            error_q      <= error_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = valid_q;
    assign bus.taken      = taken_q;
    assign bus.target     = target_q;
    assign bus.mispredict = mispredict_q;
    assign bus.misaligned = misaligned_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed ops push expected results,
// a monitor pops and compares on every output handshake.
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolver_if #(.XLEN(32)) bi  ();
    branch_resolver_if #(.XLEN(32)) bi0 ();

    branch_resolver #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    branch_resolver #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(0)) u_dut_full (
        .clk (clk),
        .rst (rst),
        .bus (bi0.slave)
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic        misal;
        logic        err;
        logic [31:0] lat;
        logic [31:0] acc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    function automatic exp_t mk(input logic tk, input logic [31:0] tg, input logic mp,
                                input logic ma, input logic er, input int lat);
        exp_t e;
        e.taken  = tk;
        e.target = tg;
        e.mis    = mp;
        e.misal  = ma;
        e.err    = er;
        e.lat    = lat;
        e.acc    = 32'd0;
        return e;
    endfunction

    // Monitor: samples after the driver has settled its inputs for this half cycle.
    exp_t me;
    bit   seen = 1'b0;
    int   vcyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (bi.out_valid && !seen) begin
                    seen = 1'b1;
                    vcyc = cyc;
                end
                if (bi.out_valid && bi.out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        me = q.pop_front();
                        chk("taken",      {31'd0, bi.taken},      {31'd0, me.taken});
                        chk("target",     bi.target,              me.target);
                        chk("mispredict", {31'd0, bi.mispredict}, {31'd0, me.mis});
                        chk("misaligned", {31'd0, bi.misaligned}, {31'd0, me.misal});
                        chk("error",      {31'd0, bi.error},      {31'd0, me.err});
                        chk("latency",    32'(vcyc) - me.acc,     me.lat);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    // Drives one request from a negedge until accepted; optionally expects acceptance on the first edge.
    task automatic drive_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] pcv, input logic [31:0] immv, input logic pt,
                            input exp_t e, input bit b2b, input bit push);
        int waits = 0;
        bit acc   = 1'b0;
        exp_t ee  = e;
        bi.in_valid   = 1'b1;
        bi.funct3     = f3;
        bi.a          = av;
        bi.b          = bv;
        bi.pc         = pcv;
        bi.imm        = immv;
        bi.pred_taken = pt;
        while (!acc && waits < 50) begin
            #1;
            acc = bi.in_ready;
            @(posedge clk);
            if (!acc) begin
                waits++;
                @(negedge clk);
            end
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if (b2b) chk("b2b_accept_waits", 32'(waits), 32'd0);
        #1;
        ee.acc = 32'(cyc);
        if (push && acc) q.push_back(ee);
        @(negedge clk);
        bi.in_valid = 1'b0;
        bi.funct3   = 3'b010;
        bi.a        = ~av;
        bi.b        = av;
        bi.pc       = 32'hDEAD_BEE0;
        bi.imm      = 32'h0000_0002;
    endtask

    task automatic wait_out();
        int n = 0;
        #1;
        while (!bi.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bi.out_valid) chk("out_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        bi.flush = 1'b0;  bi.in_valid = 1'b0;  bi.out_ready = 1'b1;  bi.funct3 = 3'b000;
        bi.a = 32'd0;  bi.b = 32'd0;  bi.pc = 32'd0;  bi.imm = 32'd0;  bi.pred_taken = 1'b0;
        bi0.flush = 1'b0; bi0.in_valid = 1'b0; bi0.out_ready = 1'b1; bi0.funct3 = 3'b000;
        bi0.a = 32'd0; bi0.b = 32'd0; bi0.pc = 32'd0; bi0.imm = 32'd0; bi0.pred_taken = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_out_valid",  {31'd0, bi.out_valid},  32'd0);
        chk("rst_in_ready",   {31'd0, bi.in_ready},   32'd0);
        chk("rst_taken",      {31'd0, bi.taken},      32'd0);
        chk("rst_target",     bi.target,              32'd0);
        chk("rst_mispredict", {31'd0, bi.mispredict}, 32'd0);
        chk("rst_misaligned", {31'd0, bi.misaligned}, 32'd0);
        chk("rst_error",      {31'd0, bi.error},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, bi.in_ready}, 32'd1);
        @(negedge clk);

        // Equal operands walk all four slices.
        drive_op(3'b000, 32'h1234_5678, 32'h1234_5678, 32'h0000_0100, 32'h0000_0040, 1'b1,
                 mk(1'b1, 32'h0000_0140, 1'b0, 1'b0, 1'b0, 4), 1'b0, 1'b1);
        wait_out(); @(negedge clk);
        // MSB slice differs: early exit after one slice.
        drive_op(3'b001, 32'hFF00_0000, 32'h0000_0000, 32'h0000_0200, 32'h0000_0010, 1'b0,
                 mk(1'b1, 32'h0000_0210, 1'b1, 1'b0, 1'b0, 1), 1'b0, 1'b1);
        wait_out(); @(negedge clk);
        drive_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0300, 32'hFFFF_FFF8, 1'b1,
                 mk(1'b1, 32'h0000_02F8, 1'b0, 1'b0, 1'b0, 1), 1'b0, 1'b1);
        wait_out(); @(negedge clk);
        drive_op(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0300, 32'hFFFF_FFF8, 1'b1,
                 mk(1'b0, 32'h0000_0304, 1'b1, 1'b0, 1'b0, 1), 1'b0, 1'b1);
        wait_out(); @(negedge clk);

        // Illegal funct3, then a back-to-back BEQ differing only in the low slice.
        drive_op(3'b011, 32'h0000_0001, 32'h0000_0002, 32'h0000_0400, 32'h0000_0080, 1'b1,
                 mk(1'b0, 32'h0000_0404, 1'b0, 1'b0, 1'b1, 1), 1'b0, 1'b1);
        wait_out();
        drive_op(3'b000, 32'h0000_0005, 32'h0000_0006, 32'h0000_0500, 32'h0000_0020, 1'b0,
                 mk(1'b0, 32'h0000_0504, 1'b0, 1'b0, 1'b0, 4), 1'b1, 1'b1);
        wait_out(); @(negedge clk);

        // Consumer stalls five cycles while a new request waits.
        bi.out_ready = 1'b0;
        drive_op(3'b101, 32'h0000_0010, 32'h8000_0000, 32'h0000_0600, 32'h0000_0100, 1'b0,
                 mk(1'b1, 32'h0000_0700, 1'b1, 1'b0, 1'b0, 1), 1'b0, 1'b1);
        wait_out();
        bi.in_valid = 1'b1; bi.funct3 = 3'b111; bi.a = 32'h55; bi.b = 32'h55;
        bi.pc = 32'hFFFF_FFFC; bi.imm = 32'h8; bi.pred_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_out_valid", {31'd0, bi.out_valid}, 32'd1);
            chk("hold_in_ready",  {31'd0, bi.in_ready},  32'd0);
            chk("hold_target",    bi.target,             32'h0000_0700);
            chk("hold_taken",     {31'd0, bi.taken},     32'd1);
        end
        bi.out_ready = 1'b1;
        drive_op(3'b111, 32'h0000_0055, 32'h0000_0055, 32'hFFFF_FFFC, 32'h0000_0008, 1'b1,
                 mk(1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 4), 1'b1, 1'b1);
        wait_out(); @(negedge clk);
        drive_op(3'b111, 32'h0000_0077, 32'h0000_0077, 32'hFFFF_FFFC, 32'h0000_0006, 1'b1,
                 mk(1'b1, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 4), 1'b0, 1'b1);
        wait_out(); @(negedge clk);

        // Same BNE on the instance without early exit.
        bi0.funct3 = 3'b001; bi0.a = 32'hFF00_0000; bi0.b = 32'h0;
        bi0.pc = 32'h800; bi0.imm = 32'h10; bi0.pred_taken = 1'b1; bi0.in_valid = 1'b1;
        #1;
        chk("full_in_ready", {31'd0, bi0.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        c0 = cyc;
        @(negedge clk);
        bi0.in_valid = 1'b0;
        n = 0;
        #1;
        while (!bi0.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("full_latency",    32'(cyc - c0),          32'd4);
        chk("full_taken",      {31'd0, bi0.taken},      32'd1);
        chk("full_target",     bi0.target,              32'h0000_0810);
        chk("full_mispredict", {31'd0, bi0.mispredict}, 32'd0);
        @(negedge clk);

        // Flush in the second busy cycle discards the op.
        drive_op(3'b000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0900, 32'h0000_0010, 1'b0,
                 mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4), 1'b0, 1'b0);
        @(negedge clk);
        bi.flush = 1'b1;
        bi.in_valid = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, bi.in_ready}, 32'd0);
        @(negedge clk);
        bi.flush = 1'b0;
        bi.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, bi.out_valid}, 32'd0);
        chk("flush_idle",      {31'd0, bi.in_ready},  32'd1);
        chk("flush_keeps_target", bi.target,          32'h0000_0002);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (bi.out_valid) n++;
        end
        chk("flush_no_result", 32'(n), 32'd0);

        // Reset mid-busy clears registered outputs at once.
        drive_op(3'b000, 32'h0000_0003, 32'h0000_0003, 32'h0000_0A00, 32'h0000_0010, 1'b0,
                 mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid",  {31'd0, bi.out_valid},  32'd0);
        chk("mid_rst_in_ready",   {31'd0, bi.in_ready},   32'd0);
        chk("mid_rst_taken",      {31'd0, bi.taken},      32'd0);
        chk("mid_rst_target",     bi.target,              32'd0);
        chk("mid_rst_misaligned", {31'd0, bi.misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, bi.out_valid}, 32'd0);
        chk("post_rst_in_ready",  {31'd0, bi.in_ready},  32'd1);
        chk("scoreboard_empty",   32'(q.size()),         32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Parametrised, multi-cycle branch condition resolver for the execute stage.
- Compares rs1/rs2 serially in CHUNK-bit slices, MSB slice first, with optional early exit.
- Computes the taken/not-taken target and flags mispredict against the fetch-stage prediction.
- Uses valid/ready handshakes on both sides so the pipeline can stall it or flush it.

Parameters:
- XLEN, 32, operand/PC width.
- CHUNK, 8, slice width compared per cycle; must divide XLEN; N = XLEN/CHUNK.
- EARLY_EXIT, 1, when 1 the compare finishes at the first differing slice; when 0 it always takes N slices.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of any in-flight or completed op.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at a rising edge.
- funct3  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- a  in  XLEN  rs1 value.
- b  in  XLEN  rs2 value.
- pc  in  XLEN  branch PC.
- imm  in  XLEN  sign-extended B-immediate.
- pred_taken  in  1  prediction from fetch.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- taken  out  1  resolved condition.
- target  out  XLEN  next PC.
- mispredict  out  1  redirect required.
- misaligned  out  1  taken target not 4-byte aligned.
- error  out  1  illegal funct3 (010/011).

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid, taken, mispredict, misaligned and error = 0; target = 0; in_ready = 0 while rst is high.
- States:
  - IDLE: in_ready = 1.
  - BUSY: slice compare in progress; in_ready = 0.
  - DONE: out_valid = 1; outputs stable; in_ready = out_ready.
- Accept (IDLE, or DONE with out_ready): latch all inputs and set slice index to N-1 (MSB slice).
  - Legal funct3 -> BUSY.
  - funct3 010/011 -> DONE at the next edge (latency 1) with error=1, taken=0, mispredict=0, misaligned=0, target = pc+4.
- Signed compare (BLT/BGE): invert bit XLEN-1 of both latched operands, then compare unsigned. All slices are compared unsigned.
- BUSY, each edge:
  - Compare the current slice and record eq/lt on the first differing slice.
  - If the slices differ and EARLY_EXIT=1, or the index is 0 -> DONE; otherwise decrement the index.
- Latency from the accept edge to the out_valid edge is m cycles, m in 1..N.
  - Equal operands always take m = N.
  - With EARLY_EXIT=1, m = N - (index of the highest differing slice).
- Condition mapping:
  - BEQ: eq. BNE: !eq.
  - BLT/BLTU: lt. BGE/BGEU: !lt.
- Target: taken ? pc+imm : pc+4, both computed modulo 2^XLEN (wrap, no overflow flag).
- mispredict = taken ^ pred_taken.
- misaligned = taken & |target[1:0].
- All outputs are registered and change only when entering DONE.
- DONE: hold every output while out_ready=0.
  - out_ready=1 and in_valid=1 -> accept the new op in the same cycle (back-to-back).
  - out_ready=1 and in_valid=0 -> IDLE, out_valid=0.
- flush (highest priority after rst): next edge -> IDLE, out_valid=0; the result is discarded; in_ready=0 during the flush cycle, so nothing is accepted.
- Inputs changing while BUSY have no effect; operands were latched at accept.
- funct3 decode uses the latched value only.

Test Plan:
- N=4, BEQ, a=b=0x12345678, pred_taken=1, pc=0x100, imm=0x40 -> out_valid 4 cycles after accept, taken=1, target=0x140, mispredict=0.
- BNE, a=0xFF000000, b=0x00000000, EARLY_EXIT=1 -> out_valid 1 cycle after accept, taken=1. The same op with EARLY_EXIT=0 -> 4 cycles.
- BLT, a=0xFFFFFFFF, b=0x00000001 -> taken=1. BLTU with the same operands -> taken=0; with pred_taken=1, mispredict=1 and target=pc+4.
- funct3=011 -> out_valid after 1 cycle, error=1, taken=0, target=pc+4. Next op funct3=000 accepted back-to-back with out_ready=1.
- Hold out_ready=0 for 5 cycles in DONE -> outputs and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new op accepted that cycle.
- Wrap and alignment:
  - BGEU a=b, pc=0xFFFFFFFC, imm=0x8 -> target=0x00000004, misaligned=0.
  - imm=0x6 -> misaligned=1.
- Abort paths: flush asserted in the 2nd BUSY cycle -> IDLE next edge, no out_valid. rst pulsed mid-BUSY -> all outputs 0 immediately.
